// File: rtl/count_lamp_s_if.sv
// Operator-request / lamp-output bundle for one count_lamp_s channel.
// MAX must match the parameter of the count_lamp_s instance it connects to.
interface count_lamp_s_if #(
  parameter int MAX = 3
) ();
  localparam int CW = $clog2(MAX);

  logic          iINC;
  logic          iFOUL;
  logic          iDEC;
  logic          iCLR;
  logic [CW-1:0] oCOUNT;
  logic [MAX-2:0] oLAMP;
  logic          oEVENT;

  modport master (
    output iINC, iFOUL, iDEC, iCLR,
    input  oCOUNT, oLAMP, oEVENT
  );

  modport slave (
    input  iINC, iFOUL, iDEC, iCLR,
    output oCOUNT, oLAMP, oEVENT
  );
endinterface

// File: rtl/count_lamp_s.sv
// Single-channel scoreboard count tracker: edge-detected inc/foul/dec requests,
// synchronous clear, thermometer lamps and a one-cycle completion event.
module count_lamp_s #(
  parameter int MAX  = 3,
  parameter bit WRAP = 1'b1,
  parameter int CW   = $clog2(MAX)
) (
  input logic           iCLK,
  input logic           iRSTn,
  count_lamp_s_if.slave bus
);

  localparam logic [CW-1:0] C_TOP      = CW'(MAX - 1);
  localparam logic [CW-1:0] C_FOUL_LIM = CW'(MAX - 2);

  logic           r_prev_inc;
  logic           r_prev_foul;
  logic           r_prev_dec;
  logic [CW-1:0]  r_count;
  logic [MAX-2:0] r_lamp;
  logic           r_event;

  logic           w_rise_inc;
  logic           w_rise_foul;
  logic           w_rise_dec;
  logic [CW-1:0]  w_next_count;
  logic [MAX-2:0] w_next_lamp;
  logic           w_next_event;

  assign w_rise_inc  = bus.iINC  & ~r_prev_inc;
  assign w_rise_foul = bus.iFOUL & ~r_prev_foul;
  assign w_rise_dec  = bus.iDEC  & ~r_prev_dec;

  // Strict priority: only the highest-priority request acts; lower rises are dropped.
  always_comb begin
    // NOTE: defaults first so every path assigns every output -- no latch.
    w_next_count = r_count;
    w_next_event = 1'b0;
    if (bus.iCLR) begin
      w_next_count = '0;
    end else if (w_rise_dec) begin
      if (r_count != '0) w_next_count = r_count - 1'b1;
    end else if (w_rise_inc) begin
      if (r_count < C_TOP) begin
        w_next_count = r_count + 1'b1;
      end else begin
        w_next_event = 1'b1;
        w_next_count = WRAP ? '0 : C_TOP;
      end
    end else if (w_rise_foul) begin
      if (r_count < C_FOUL_LIM) w_next_count = r_count + 1'b1;
    end
  end

  // Lamps decode the next count so they switch on the same edge as oCOUNT.
  always_comb begin
    w_next_lamp = '0;
    for (int i = 0; i < MAX - 1; i++) begin
      w_next_lamp[i] = (w_next_count > CW'(i));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // sample their inputs from the same pre-edge values.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      r_prev_inc  <= 1'b0;
      r_prev_foul <= 1'b0;
      r_prev_dec  <= 1'b0;
      r_count     <= '0;
      r_lamp      <= '0;
      r_event     <= 1'b0;
    end else begin
      // Edge history tracks the raw inputs every clock, even during clear.
      r_prev_inc  <= bus.iINC;
      r_prev_foul <= bus.iFOUL;
      r_prev_dec  <= bus.iDEC;
      r_count     <= w_next_count;
      r_lamp      <= w_next_lamp;
      r_event     <= w_next_event;
    end
  end

  assign bus.oCOUNT = r_count;
  assign bus.oLAMP  = r_lamp;
  assign bus.oEVENT = r_event;

endmodule

// File: tb/tb_count_lamp_s.sv
// Scoreboard bench for count_lamp_s: a MAX=3/WRAP=1 channel and a MAX=4/WRAP=0
// channel run side by side; expected outputs are queued per driven cycle.
module tb_count_lamp_s;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  count_lamp_s_if #(.MAX(3)) bus_a ();
  count_lamp_s_if #(.MAX(4)) bus_b ();

  count_lamp_s #(.MAX(3), .WRAP(1'b1)) u_a (.iCLK(clk), .iRSTn(rst_n), .bus(bus_a.slave));
  count_lamp_s #(.MAX(4), .WRAP(1'b0)) u_b (.iCLK(clk), .iRSTn(rst_n), .bus(bus_b.slave));

  typedef struct packed {
    logic [3:0]  cnt;
    logic [14:0] lamp;
    logic        ev;
  } exp_t;

  // Request encoding: {clr, dec, foul, inc}
  localparam logic [3:0] R_NONE = 4'b0000;
  localparam logic [3:0] R_INC  = 4'b0001;
  localparam logic [3:0] R_FOUL = 4'b0010;
  localparam logic [3:0] R_DEC  = 4'b0100;
  localparam logic [3:0] R_CLR  = 4'b1000;

  exp_t q_a[$];
  exp_t q_b[$];
  int   m_cnt  [2];
  logic [2:0] m_prev [2];   // {dec, foul, inc}
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k]  = 0;
      m_prev[k] = 3'b000;
    end
  endfunction

  // Behavioural reference written from the channel description.
  function automatic exp_t model_step(input int id, input logic [3:0] req,
                                      input int max, input bit wrap);
    exp_t e;
    logic ri, rf, rd;
    ri = req[0] & ~m_prev[id][0];
    rf = req[1] & ~m_prev[id][1];
    rd = req[2] & ~m_prev[id][2];
    e = '0;
    if (req[3])          m_cnt[id] = 0;
    else if (rd)         begin if (m_cnt[id] > 0) m_cnt[id]--; end
    else if (ri) begin
      if (m_cnt[id] < max - 1) m_cnt[id]++;
      else begin
        e.ev = 1'b1;
        m_cnt[id] = wrap ? 0 : max - 1;
      end
    end
    else if (rf)         begin if (m_cnt[id] < max - 2) m_cnt[id]++; end
    m_prev[id] = req[2:0];
    e.cnt = 4'(m_cnt[id]);
    for (int i = 0; i < max - 1; i++) e.lamp[i] = (m_cnt[id] > i);
    return e;
  endfunction

  task automatic apply_inputs(input logic [3:0] ra, input logic [3:0] rb);
    bus_a.iINC = ra[0]; bus_a.iFOUL = ra[1]; bus_a.iDEC = ra[2]; bus_a.iCLR = ra[3];
    bus_b.iINC = rb[0]; bus_b.iFOUL = rb[1]; bus_b.iDEC = rb[2]; bus_b.iCLR = rb[3];
  endtask

  // One clock: drive at negedge, queue expectations, compare #1 after posedge.
  task automatic drive(input logic [3:0] ra, input logic [3:0] rb);
    exp_t e;
    @(negedge clk);
    apply_inputs(ra, rb);
    q_a.push_back(model_step(0, ra, 3, 1'b1));
    q_b.push_back(model_step(1, rb, 4, 1'b0));
    @(posedge clk);
    #1;
    e = q_a.pop_front();
    check("a_count", int'(bus_a.oCOUNT), int'(e.cnt));
    check("a_lamp",  int'(bus_a.oLAMP),  int'(e.lamp));
    check("a_event", int'(bus_a.oEVENT), int'(e.ev));
    e = q_b.pop_front();
    check("b_count", int'(bus_b.oCOUNT), int'(e.cnt));
    check("b_lamp",  int'(bus_b.oLAMP),  int'(e.lamp));
    check("b_event", int'(bus_b.oEVENT), int'(e.ev));
  endtask

  task automatic pulse(input logic [3:0] ra, input logic [3:0] rb);
    repeat (4) drive(ra, rb);
    repeat (4) drive(R_NONE, R_NONE);
  endtask

  initial begin
    rst_n = 1'b0;
    apply_inputs(R_NONE, R_NONE);
    model_reset();
    #12;
    check("rst_a_count", int'(bus_a.oCOUNT), 0);
    check("rst_a_lamp",  int'(bus_a.oLAMP),  0);
    check("rst_a_event", int'(bus_a.oEVENT), 0);
    check("rst_b_count", int'(bus_b.oCOUNT), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: three increments wrap 1, 2, 0 with a single event
    repeat (3) pulse(R_INC, R_NONE);
    check("t1_count", int'(bus_a.oCOUNT), 0);
    check("t1_lamp",  int'(bus_a.oLAMP),  0);

    // 2: fouls stop at MAX-2, then INC completes
    repeat (4) pulse(R_FOUL, R_NONE);
    check("t2_foul_count", int'(bus_a.oCOUNT), 1);
    check("t2_foul_lamp",  int'(bus_a.oLAMP),  1);
    pulse(R_INC, R_NONE);
    check("t2_inc_lamp", int'(bus_a.oLAMP), 3);
    pulse(R_INC, R_NONE);
    check("t2_wrap_count", int'(bus_a.oCOUNT), 0);

    // 3: held INC acts once; DEC floors at 0; DEC from 2 gives 1
    repeat (20) drive(R_INC, R_NONE);
    repeat (4)  drive(R_NONE, R_NONE);
    check("t3_held_count", int'(bus_a.oCOUNT), 1);
    pulse(R_DEC, R_NONE);
    pulse(R_DEC, R_NONE);
    check("t3_dec_floor", int'(bus_a.oCOUNT), 0);
    pulse(R_INC, R_NONE);
    pulse(R_INC, R_NONE);
    pulse(R_DEC, R_NONE);
    check("t3_dec_count", int'(bus_a.oCOUNT), 1);

    // 4: clear beats a simultaneous INC rise; the rise is not replayed
    pulse(R_INC, R_NONE);
    drive(R_CLR | R_INC, R_NONE);
    check("t4_clr_event", int'(bus_a.oEVENT), 0);
    repeat (3) drive(R_INC, R_NONE);
    check("t4_no_replay", int'(bus_a.oCOUNT), 0);
    drive(R_NONE, R_NONE);

    // 5: MAX=4, WRAP=0 saturates at 3 and fires on every completing INC
    repeat (4) pulse(R_NONE, R_INC);
    check("t5_sat_count", int'(bus_b.oCOUNT), 3);
    check("t5_sat_lamp",  int'(bus_b.oLAMP),  7);
    repeat (3) drive(R_NONE, R_INC);
    check("t5_fifth_event", int'(bus_b.oEVENT), 0);
    drive(R_NONE, R_NONE);
    drive(R_NONE, R_INC);
    check("t5_fifth_event_hi", int'(bus_b.oEVENT), 1);
    check("t5_fifth_count", int'(bus_b.oCOUNT), 3);
    drive(R_NONE, R_NONE);

    // 6: asynchronous reset mid-cycle, then a held INC rises once after release
    pulse(R_INC, R_NONE);
    pulse(R_INC, R_NONE);
    check("t6_pre_count", int'(bus_a.oCOUNT), 2);
    @(negedge clk);
    apply_inputs(R_INC, R_NONE);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("t6_async_count", int'(bus_a.oCOUNT), 0);
    check("t6_async_lamp",  int'(bus_a.oLAMP),  0);
    check("t6_async_b",     int'(bus_b.oCOUNT), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(R_INC, R_NONE);
    check("t6_first_clk", int'(bus_a.oCOUNT), 1);
    repeat (3) drive(R_INC, R_NONE);
    drive(R_NONE, R_NONE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/count_lamp_s.md
# count_lamp_s

Parametrised successor to the strike counter for the scoreboard: a single-channel count tracker that drives a row of thermometer-coded lamps. Instantiated once each for balls (MAX=4), strikes (MAX=3) and outs (MAX=3). It adds the following over the strike counter:
- rising-edge detection on the operator inputs;
- a foul input that cannot complete the count;
- an umpire-correction decrement;
- a one-cycle completion event that feeds the next channel (strike-out → out, ball four → walk logic).

## Interface
Parameters:
- MAX, 3, counts per cycle; legal range 2..16. Count is held in 0..MAX-1.
- WRAP, 1, completion behaviour. 1 = return to 0 on completion. 0 = hold at MAX-1.
- CW, $clog2(MAX), count width (derived; do not override).

Ports:
- iCLK  in  1  system clock, rising edge.
- iRSTn  in  1  asynchronous active-low reset.
- iINC  in  1  increment request; level from debouncer, acted on at rising edge.
- iFOUL  in  1  foul request; level, acted on at rising edge.
- iDEC  in  1  correction (undo one count); level, acted on at rising edge.
- iCLR  in  1  synchronous clear; level-sensitive, active-high (new batter / new inning).
- oCOUNT  out  CW  binary count.
- oLAMP  out  MAX-1  thermometer lamps; bit i = (oCOUNT > i).
- oEVENT  out  1  completion pulse, one cycle.

## Operation
- Edge detect:
  - One prev-level register per request input (iINC, iFOUL, iDEC).
  - rise_x = x & ~prev_x.
  - prev registers reset to 0, so an input already high at reset release produces one rise on the first clock.
- Priority per clock, highest first. Exactly one action per clock; lower-priority rises in the same cycle are discarded, not queued.
  - iCLR = 1: count → 0, oEVENT = 0.
  - rise_DEC: if count > 0, count → count-1. At 0, no change.
  - rise_INC:
    - If count < MAX-1: count → count+1.
    - If count = MAX-1: oEVENT = 1, and count → 0 (WRAP=1) or stays MAX-1 (WRAP=0).
  - rise_FOUL:
    - If count < MAX-2: count → count+1.
    - Otherwise no change. Foul never completes the count and never raises oEVENT.
  - Otherwise: hold. oEVENT = 0.
- prev registers update every clock regardless of iCLR or priority. A held input therefore acts once per press.
- Arithmetic is unsigned CW-bit. Count never leaves 0..MAX-1.
- oLAMP is registered from next-count, not decoded from oCOUNT combinationally, so lamps and count change on the same edge.
- MAX=3 lamp encoding: 0 → 2'b00, 1 → 2'b01, 2 → 2'b11. This matches the existing strike display.

## Timing
- Reset (iRSTn low, asynchronous): oCOUNT = 0, oLAMP = 0, oEVENT = 0, all prev registers = 0. Takes effect immediately, mid-operation included.
- Reset deassertion is synchronous to iCLK, handled by the top-level reset synchroniser.
- Latency: the input is first sampled high at edge N; oCOUNT, oLAMP and oEVENT reflect the action after edge N, i.e. one-cycle registered latency.
- oEVENT is high for exactly the cycle after edge N, then 0. Back-to-back completions need a new rise, so events are at least 2 cycles apart.
- iCLR and a rise in the same cycle: clear wins. That rise is consumed (prev updated) and is not replayed after iCLR drops.
- iINC and iFOUL rising together: INC acts, FOUL is lost.
- All outputs are glitch-free registered signals and may drive lamp drivers directly.

## Test plan
All scenarios use defaults (MAX=3, WRAP=1) unless noted.
1. Reset, then three separate iINC pulses (each 4 cycles high, 4 low) → oCOUNT 1, 2, 0; oLAMP 01, 11, 00. oEVENT high for one cycle only, on the third pulse.
2. From count 0: four iFOUL pulses → oCOUNT 1, 1, 1, 1; oLAMP 01; oEVENT never asserts. Then one iINC → count 2. Then iINC → count 0 with oEVENT.
3. iINC held high 20 cycles → a single increment, 0 → 1. iDEC pulse at count 0 → count stays 0. iDEC pulse at count 2 → count 1.
4. At count 2, iCLR and a rising iINC in the same cycle → count 0, oEVENT 0. After iCLR drops with iINC still high → no further change.
5. MAX=4, WRAP=0: four iINC pulses → oCOUNT 1, 2, 3, 3; oLAMP 001, 011, 111, 111. oEVENT asserts on the fourth pulse only, and again on a fifth pulse.
6. iRSTn asserted mid-cycle at count 2 with iINC high → outputs 0 immediately. After release with iINC still high → one increment, to count 1, on the first clock.
